// File: rtl/alu_64_if.sv
// Operand/result bundle for the 64-bit registered ALU.
//
// Handshake: there is none. Every rising clk edge captures mode/a/b, and the
// matching out/CC become visible right after that edge. They stay stable
// until the next edge, so throughput is one operation per clock.
interface alu_64_if;
  logic [1:0]  mode;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] out;
  logic [2:0]  CC;

  // The driver of operands and consumer of results.
  modport master (
    output mode,
    output a,
    output b,
    input  out,
    input  CC
  );

  // The ALU itself.
  modport slave (
    input  mode,
    input  a,
    input  b,
    output out,
    output CC
  );
endinterface

// File: rtl/alu_64.sv
// 64-bit ALU with a single register stage on result and condition codes.
// Operations: 0 = ADD, 1 = SUB, 2 = AND, 3 = XOR.
// CC[2] = ZF (result is zero), CC[1] = SF (result bit 63), CC[0] = OF.
module alu_64 (
  input  logic     clk,
  input  logic     rst,
  alu_64_if.slave  bus
);

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_AND = 2'd2;
  localparam logic [1:0] MODE_XOR = 2'd3;

  logic [63:0] w_b_op;
  logic        w_cin;
  logic [63:0] w_arith;
  logic [63:0] w_result;
  logic        w_zf;
  logic        w_sf;
  logic        w_of;
  logic [63:0] r_out;
  logic [2:0]  r_cc;

  // Shared adder: SUB is a + ~b + 1, so one adder serves both arithmetic
  // modes. Overflow uses the effective second operand, which turns the SUB
  // rule (sign of a differs from sign of b) into the ADD rule on ~b.
  always_comb begin
    w_b_op   = bus.b;
    w_cin    = 1'b0;
    w_result = '0;
    w_of     = 1'b0;
    if (bus.mode == MODE_SUB) begin
      w_b_op = ~bus.b;
      w_cin  = 1'b1;
    end
    w_arith = bus.a + w_b_op + {63'd0, w_cin};
    case (bus.mode)
      MODE_ADD, MODE_SUB: begin
        w_result = w_arith;
        w_of     = (bus.a[63] == w_b_op[63]) && (w_arith[63] != bus.a[63]);
      end
      MODE_AND: w_result = bus.a & bus.b;
      MODE_XOR: w_result = bus.a ^ bus.b;
      default:  w_result = '0;
    endcase
    w_zf = (w_result == 64'd0);
    w_sf = w_result[63];
  end

  // Result and flag register; reset wins over the operation sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= 64'd0;
      r_cc  <= 3'b000;
    end else begin
      r_out <= w_result;
      r_cc  <= {w_zf, w_sf, w_of};
    end
  end

  assign bus.out = r_out;
  assign bus.CC  = r_cc;

endmodule

// File: tb/tb_alu_64.sv
// Directed-vector bench for alu_64: table of hand-computed results, a
// back-to-back stream with hold checks, and reset corner sequences.
module tb_alu_64;

  typedef struct packed {
    logic [1:0]  mode;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_out;
    logic [2:0]  exp_cc;
  } vec_t;

  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] AND = 2'd2;
  localparam logic [1:0] XOR = 2'd3;
  localparam int NV = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs [NV];
  logic [66:0] exp_q[$];

  alu_64_if bus ();

  alu_64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] exp_o, input logic [2:0] exp_c);
    total++;
    if (bus.out !== exp_o || bus.CC !== exp_c) begin
      bad++;
      $display("FAIL %s: out=%h CC=%b, required out=%h CC=%b",
               name, bus.out, bus.CC, exp_o, exp_c);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [63:0] av, input logic [63:0] bv);
    bus.mode = m;
    bus.a    = av;
    bus.b    = bv;
  endtask

  initial begin
    logic [66:0] e;
    total = 0;
    bad   = 0;

    vecs[0]  = '{ADD, 64'd54, 64'd46, 64'd100, 3'b000};
    vecs[1]  = '{ADD, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b011};
    vecs[2]  = '{ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 3'b101};
    vecs[3]  = '{SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'hFFFF_FFFF_FFFF_FFF5, 3'b010};
    vecs[4]  = '{SUB, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF1, 64'd1015, 3'b000};
    vecs[5]  = '{SUB, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 3'b001};
    vecs[6]  = '{SUB, 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b011};
    vecs[7]  = '{AND, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010};
    vecs[8]  = '{XOR, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'b100};
    vecs[9]  = '{AND, 64'd12548000, 64'd1012545, 64'h0000_0000_000F_7300, 3'b000};
    vecs[10] = '{ADD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 3'b100};
    vecs[11] = '{SUB, 64'd0, 64'd0, 64'd0, 3'b100};
    vecs[12] = '{XOR, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010};
    vecs[13] = '{AND, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0003, 64'h8000_0000_0000_0001, 3'b010};
    vecs[14] = '{ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 3'b011};
    vecs[15] = '{SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010};

    // Reset with nonzero operands on the inputs
    rst = 1'b1;
    drive(ADD, 64'd7, 64'd9);
    repeat (2) @(posedge clk);
    #1 check("reset_state", 64'd0, 3'b000);

    // Table: one vector per cycle, checked 1 ns after the capturing edge
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].mode, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_cc);
      @(negedge clk);
    end

    // Back-to-back stream in reverse order, with a hold check after each
    // input change to catch any combinational leak or early update.
    for (int i = NV - 1; i >= 0; i--) begin
      drive(vecs[i].mode, vecs[i].a, vecs[i].b);
      exp_q.push_back({vecs[i].exp_out, vecs[i].exp_cc});
      if (i != NV - 1) begin
        #1 check($sformatf("hold%0d", i), e[66:3], e[2:0]);
      end
      @(posedge clk);
      e = exp_q.pop_front();
      #1 check($sformatf("stream%0d", i), e[66:3], e[2:0]);
      @(negedge clk);
    end

    // Reset mid-stream with nonzero outputs and arbitrary inputs
    drive(ADD, 64'd54, 64'd46);
    @(posedge clk);
    #1 check("pre_reset", 64'd100, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    drive(AND, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 check("mid_reset", 64'd0, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    drive(SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10);
    @(posedge clk);
    #1 check("post_reset", 64'hFFFF_FFFF_FFFF_FFF5, 3'b010);

    // Mode switch with identical operands on consecutive edges
    @(negedge clk);
    drive(XOR, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 check("mode_sw_xor", 64'd0, 3'b100);
    @(negedge clk);
    drive(ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 check("mode_sw_add", 64'hFFFF_FFFF_FFFF_FFFE, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_64.md
ALU_64 -- requirements
Module: alu_64

Interface
REQ-001 Parameters: none; datapath width fixed at 64 bits, mode width 2 bits, flag width 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-004 mode  input  2  operation select: 0 = ADD, 1 = SUB, 2 = AND, 3 = XOR.
REQ-005 a  input  64  operand A, two's complement.
REQ-006 b  input  64  operand B, two's complement.
REQ-007 out  output  64  registered result.
REQ-008 CC  output  3  registered condition codes: CC[2] = ZF, CC[1] = SF, CC[0] = OF.

Function
REQ-009 ADD (mode 0) SHALL compute out = (a + b) mod 2^64; carry-out discarded.
REQ-010 SUB (mode 1) SHALL compute out = (a - b) mod 2^64, i.e. a + ~b + 1.
REQ-011 AND (mode 2) SHALL compute out = a & b, bitwise.
REQ-012 XOR (mode 3) SHALL compute out = a ^ b, bitwise.
REQ-013 ZF SHALL be 1 iff the 64-bit result equals zero, in every mode.
REQ-014 SF SHALL equal result bit 63, in every mode.
REQ-015 OF for ADD SHALL be 1 iff a[63] == b[63] and result[63] != a[63].
REQ-016 OF for SUB SHALL be 1 iff a[63] != b[63] and result[63] != a[63].
REQ-017 OF SHALL be 0 for AND and XOR.
REQ-018 Result and flags SHALL be computed combinationally from a, b and mode, then captured into the out/CC registers on each rising clk edge when rst = 0.
REQ-019 Latency SHALL be exactly 1 cycle: inputs present at edge N appear on out/CC after edge N and hold until edge N+1.
REQ-020 No handshake; a new operation is accepted every cycle, with throughput 1 per clock.
REQ-021 A mode change SHALL take effect at the next edge with no pipeline bubble or stale mixing of modes.
REQ-022 Outputs SHALL never change between clock edges, with no combinational path from the inputs to out/CC.

Reset
REQ-023 When rst = 1 at a rising edge, out SHALL become 64'h0 and CC SHALL become 3'b000, regardless of a, b and mode.
REQ-024 Reset SHALL take priority over computation; asserting rst mid-stream discards the operation sampled at that edge.
REQ-025 After rst deasserts, the first edge with rst = 0 SHALL register a valid result for the inputs at that edge.

Verification
REQ-026 ADD scenarios:
- a = 54, b = 46 -> out = 100, CC = 000.
- a = 2^62, b = 2^62 -> out = 64'h8000_0000_0000_0000, CC = 011.
- a = b = 64'h8000_0000_0000_0000 -> out = 0, CC = 101.
REQ-027 SUB scenarios:
- a = -1, b = 10 -> out = -11, CC = 010.
- a = 1000, b = -15 -> out = 1015, CC = 000.
- a = 64'h8000_0000_0000_0000, b = 2^62 -> out = 64'h4000_0000_0000_0000, CC = 001.
- a = 2^62, b = -(2^62) -> out = 64'h8000_0000_0000_0000, CC = 011.
REQ-028 Logic scenarios:
- AND, a = b = all-ones -> out = all-ones, CC = 010.
- XOR, same operands -> out = 0, CC = 100.
- AND, a = 12548000, b = 1012545 -> out = their bitwise AND, with OF = 0.
REQ-029 Latency check: change inputs every cycle across all four modes -> each out/CC matches the prior edge's inputs exactly, with no missed or duplicated results.
REQ-030 Reset check: with outputs nonzero, assert rst for one edge with arbitrary inputs -> out = 0, CC = 000; deassert -> next edge shows the correct result.
